// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and slice helper for the multi-port register file
// Contents: FSM state type (CLEAR, READY), default XLEN/NREGS, packed-slice offset helper.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Low bit of slice idx inside a packed vector of width-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with zero-register check and optional bypass
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               high while the clear sweep runs; forces rd_data to 0
//   rd_en, rd_addr      read enable and address for this port
//   regs                current register contents
//   wr_en/addr/data     write port, used only by the bypass comparator
//   rd_data             registered read data (1-cycle latency, holds when rd_en low)
// Build option: REGFILE_BYPASS_EN selects write-first on a same-cycle address match.
module regfile_rd_port #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic            bypass_hit;
    logic [XLEN-1:0] rd_value;

    always_comb begin
        bypass_hit = BYPASS_EN && wr_en && (wr_addr == rd_addr);
        rd_value   = regs[rd_addr];
        // Register 0 is never stored; the zero check masks whatever sits in slot 0
        // and also suppresses the bypass for a write aimed at x0.
        if (rd_addr == '0) begin
            rd_value = '0;
        end else if (bypass_hit) begin
            rd_value = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_value;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with reset clear sweep
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   init_done    high once registers 1..NREGS-1 have been cleared
//   wr_en, wr_addr, wr_data            single write port (ignored during sweep, x0 is a no-op)
//   rd_en[NRD], rd_addr[NRD*AW]        per-port read enable and packed addresses
//   rd_data[NRD*XLEN]                  packed registered read data
// Build option: REGFILE_BYPASS_EN (write-first same-cycle read; default read-first).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data
);

    rf_state_e       state;
    rf_state_e       state_next;
    logic [AW-1:0]   sweep_cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic            write_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        write_ok   = 1'b0;
        case (state)
            CLEAR: begin
                if (sweep_cnt == AW'(NREGS - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                write_ok = wr_en && (wr_addr != '0);
            end
            default: state_next = CLEAR;
        endcase
    end

    // Sweep starts at 1 because register 0 has no storage to clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt <= AW'(1);
            init_done <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                sweep_cnt <= sweep_cnt + AW'(1);
            end
            init_done <= (state_next == READY);
        end
    end

    // Storage has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[sweep_cnt] <= '0;
            end else if (write_ok) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        regfile_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd_port (
            .clk     (clk),
            .rst     (rst),
            .clear   (state == CLEAR),
            .rd_en   (rd_en[g]),
            .rd_addr (rd_addr[slice_lo(g, AW) +: AW]),
            .regs    (regs),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[slice_lo(g, XLEN) +: XLEN])
        );
    end

endmodule
